pipe_dadda_mul: RTL and testbench



---
 rtl/pipe_dadda_mul.sv | 245 ++++++++++++++++++++++++
 tb/tb_pipe_dadda_mul.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_dadda_mul.sv
// Pipelined signed/unsigned multiplier.
// Baugh-Wooley partial products are reduced row-wise along the Dadda height
// sequence (2, 3, 4, 6, 9, ...) using 3:2 carry-save compressors. The levels
// are spread across the pipeline stages, and a carry-lookahead adder forms the
// product in front of the output register. Each stage carries its own valid
// bit, mode and tag. A combinational ready chain lets an empty stage fill even
// while a stage downstream of it is stalled.
module pipe_dadda_mul #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 out_signed,
  output logic [TAG_W-1:0]     out_tag,
  output logic [2:0]           occupancy
);

  localparam int PW   = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the signed-mode constant.
  localparam int MAXR = WIDTH + 1;

  typedef logic [MAXR-1:0][PW-1:0] rows_t;

  // Largest Dadda height strictly below h.
  function automatic int next_height(input int h);
    int d;
    d = 2;
    while (((d * 3) / 2) < h) d = (d * 3) / 2;
    return d;
  endfunction

  // Number of rows present after k reduction levels.
  function automatic int height_at(input int k);
    int h;
    h = MAXR;
    for (int j = 0; j < k; j++) begin
      if (h > 2) h = next_height(h);
    end
    return h;
  endfunction

  // Reduction levels needed to go from MAXR rows down to two.
  function automatic int num_levels();
    int h;
    int n;
    h = MAXR;
    n = 0;
    while (h > 2) begin
      h = next_height(h);
      n++;
    end
    return n;
  endfunction

  localparam int NLEV = num_levels();

  // One reduction level: (h-d) full-adder rows turn h rows into d rows.
  // Rows that are not compressed move down so the live rows stay packed at
  // the bottom of the array.
  function automatic rows_t csa_level(input rows_t x, input int h, input int d);
    rows_t o;
    int    n;
    o = '0;
    n = h - d;
    for (int c = 0; c < n; c++) begin
      o[2*c]   = x[3*c] ^ x[3*c+1] ^ x[3*c+2];
      o[2*c+1] = ((x[3*c] & x[3*c+1]) | (x[3*c] & x[3*c+2]) |
                  (x[3*c+1] & x[3*c+2])) << 1;
    end
    for (int r = 3 * n; r < h; r++) o[r-n] = x[r];
    return o;
  endfunction

  // Final carry-propagate adder on rows 0 and 1. It uses 4-bit lookahead
  // groups: inside a group every carry is a flat generate/propagate
  // expression, and the group carries chain from one group to the next.
  // The carry out of the top bit is dropped because the product wraps
  // modulo 2^PW.
  function automatic logic [PW-1:0] cla_add(input rows_t r);
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] s;
    logic          c_grp;
    logic          c_out;
    logic          c_bit;
    logic          term;
    int            n;
    g     = r[0] & r[1];
    p     = r[0] ^ r[1];
    s     = '0;
    c_grp = 1'b0;
    c_out = 1'b0;
    for (int base = 0; base < PW; base += 4) begin
      n = ((PW - base) < 4) ? (PW - base) : 4;
      for (int j = 0; j <= n; j++) begin
        c_bit = c_grp;
        for (int k = base; k < base + j; k++) c_bit = c_bit & p[k];
        for (int k = base; k < base + j; k++) begin
          term = g[k];
          for (int m = k + 1; m < base + j; m++) term = term & p[m];
          c_bit = c_bit | term;
        end
        if (j < n) s[base+j] = p[base+j] ^ c_bit;
        else       c_out = c_bit;
      end
      c_grp = c_out;
    end
    return s;
  endfunction

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_sgn;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [2:0]        r_occ;

  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_ld;
  logic [STAGES-1:0] w_up_v;
  logic [STAGES-1:0] w_up_sgn;
  logic [TAG_W-1:0]  w_up_tag [STAGES];
  logic [STAGES-1:0] w_v_next;
  logic [2:0]        w_occ_next;
  rows_t             w_pp;
  rows_t             w_stage_in [STAGES];
  logic [PW-1:0]     w_prod;

  // Partial products. In signed mode, a term that uses exactly one sign bit
  // is complemented, and the extra row holds the 2^W + 2^(2W-1) correction.
  always_comb begin
    w_pp = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        w_pp[j][i+j] = (in_a[i] & in_b[j]) ^
                       (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    if (in_signed) begin
      w_pp[WIDTH][WIDTH] = 1'b1;
      w_pp[WIDTH][PW-1]  = 1'b1;
    end
  end

  assign w_stage_in[0] = w_pp;

  // Ready chain, upstream selection, next valid bits and occupancy.
  // rdy[i] is high when out_ready is high or when any stage from i to the
  // output is empty. It depends only on the registered valid bits.
  always_comb begin
    w_up_v[0]   = in_valid;
    w_up_sgn[0] = in_signed;
    w_up_tag[0] = in_tag;
    for (int s = 1; s < STAGES; s++) begin
      w_up_v[s]   = r_v[s-1];
      w_up_sgn[s] = r_sgn[s-1];
      w_up_tag[s] = r_tag[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      w_rdy[s] = out_ready;
      for (int k = s; k < STAGES; k++) begin
        if (!r_v[k]) w_rdy[s] = 1'b1;
      end
    end
    w_occ_next = '0;
    for (int s = 0; s < STAGES; s++) begin
      w_ld[s]     = w_rdy[s] & w_up_v[s];
      w_v_next[s] = w_rdy[s] ? w_up_v[s] : r_v[s];
      w_occ_next  = w_occ_next + {2'b00, w_v_next[s]};
    end
  end

  // Per-stage valid, mode and tag, plus occupancy kept in step with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_sgn <= '0;
      r_occ <= '0;
      for (int s = 0; s < STAGES; s++) r_tag[s] <= '0;
    end else begin
      r_v   <= w_v_next;
      r_occ <= w_occ_next;
      for (int s = 0; s < STAGES; s++) begin
        if (w_ld[s]) begin
          r_sgn[s] <= w_up_sgn[s];
          r_tag[s] <= w_up_tag[s];
        end
      end
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = (gi * NLEV) / STAGES;
    localparam int HI = ((gi + 1) * NLEV) / STAGES;

    rows_t w_seg;

    // This stage's share of the reduction levels, [LO, HI).
    always_comb begin
      w_seg = w_stage_in[gi];
      for (int k = 0; k < NLEV; k++) begin
        if (k >= LO && k < HI) w_seg = csa_level(w_seg, height_at(k), height_at(k + 1));
      end
    end

    if (gi < STAGES - 1) begin : g_mid
      rows_t r_rows;

      // Intermediate carry-save state for this stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_rows <= '0;
        else if (w_ld[gi]) r_rows <= w_seg;
      end

      assign w_stage_in[gi+1] = r_rows;
    end else begin : g_last
      logic [PW-1:0] r_prod;

      // Output stage: the final adder result is held until it is consumed.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_prod <= '0;
        else if (w_ld[gi]) r_prod <= cla_add(w_seg);
      end

      assign w_prod = r_prod;
    end
  end

  assign in_ready   = rst_n & w_rdy[0];
  assign out_valid  = r_v[STAGES-1];
  assign out_signed = r_sgn[STAGES-1];
  assign out_tag    = r_tag[STAGES-1];
  assign out_prod   = w_prod;
  assign occupancy  = r_occ;

endmodule

// File: tb/tb_pipe_dadda_mul.sv
// Bench for pipe_dadda_mul. Four WIDTH=4 instances (STAGES 1..4) share one
// stimulus; each scenario observes one instance against a queue-based
// arithmetic reference model.
module tb_pipe_dadda_mul;

  localparam int W  = 4;
  localparam int TW = 4;
  localparam int ND = 4;

  typedef struct {
    logic [TW-1:0]  tag;
    logic           sgn;
    logic [2*W-1:0] prod;
    int             cyc;
  } rec_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_signed = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_a      = '0;
  logic [W-1:0]  in_b      = '0;
  logic [TW-1:0] in_tag    = '0;

  logic           w_in_ready  [ND];
  logic           w_out_valid [ND];
  logic [2*W-1:0] w_prod      [ND];
  logic           w_osgn      [ND];
  logic [TW-1:0]  w_otag      [ND];
  logic [2:0]     w_occ       [ND];

  rec_t          exp_q[$];
  rec_t          obs_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  logic [TW-1:0] next_tag = '0;

  logic [W-1:0]   dir_a   [5] = '{4'h8, 4'h8, 4'hF, 4'hF, 4'hF};
  logic [W-1:0]   dir_b   [5] = '{4'h8, 4'h7, 4'h1, 4'hF, 4'h8};
  logic           dir_s   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [2*W-1:0] dir_exp [5] = '{8'h40, 8'hC8, 8'hFF, 8'hE1, 8'h78};

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    pipe_dadda_mul #(.WIDTH(W), .STAGES(gi + 1), .TAG_W(TW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (w_in_ready[gi]),
      .in_signed  (in_signed),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_tag     (in_tag),
      .out_valid  (w_out_valid[gi]),
      .out_ready  (out_ready),
      .out_prod   (w_prod[gi]),
      .out_signed (w_osgn[gi]),
      .out_tag    (w_otag[gi]),
      .occupancy  (w_occ[gi])
    );
  end

  function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    int ia;
    int ib;
    int p;
    if (s) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    p = ia * ib;
    return p[2*W-1:0];
  endfunction

  task automatic drive(input logic v, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid  = v;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    in_tag    = next_tag;
  endtask

  // Logs the transfers of instance d in this cycle, then steps to the next edge.
  task automatic tick(input int d, output bit acc);
    rec_t r;
    #1;
    acc = in_valid && w_in_ready[d];
    if (acc) begin
      r.tag  = in_tag;
      r.sgn  = in_signed;
      r.prod = ref_prod(in_signed, in_a, in_b);
      r.cyc  = cyc;
      exp_q.push_back(r);
      next_tag = next_tag + 1'b1;
    end
    if (w_out_valid[d] && out_ready) begin
      r.tag  = w_otag[d];
      r.sgn  = w_osgn[d];
      r.prod = w_prod[d];
      r.cyc  = cyc;
      obs_q.push_back(r);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    next_tag = '0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if ({w_out_valid[d], w_prod[d], w_osgn[d], w_otag[d], w_occ[d], w_in_ready[d]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state d=%0d: got v=%b p=%h s=%b t=%h occ=%0d rdy=%b, expected all 0",
                 d, w_out_valid[d], w_prod[d], w_osgn[d], w_otag[d], w_occ[d], w_in_ready[d]);
      end
    end
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (w_in_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_after_reset d=%0d: got %b expected 1", d, w_in_ready[d]);
      end
    end
  endtask

  task automatic test_directed();
    bit acc;
    int d;
    d = 1;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.delete();
      obs_q.delete();
      drive(1'b1, dir_s[i], dir_a[i], dir_b[i]);
      tick(d, acc);
      drive(1'b0, 1'b0, 4'h0, 4'h0);
      for (int t = 0; t < 8 && obs_q.size() == 0; t++) tick(d, acc);
      n_tests++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
        n_fail++;
        $display("FAIL directed_count op=%0d: got %0d results expected 1", i, obs_q.size());
      end else begin
        n_tests++;
        if ({obs_q[0].prod, obs_q[0].tag, obs_q[0].sgn} !== {dir_exp[i], 4'(i), dir_s[i]}) begin
          n_fail++;
          $display("FAIL directed_result op=%0d: got prod=%h tag=%h sgn=%b expected prod=%h tag=%h sgn=%b",
                   i, obs_q[0].prod, obs_q[0].tag, obs_q[0].sgn, dir_exp[i], 4'(i), dir_s[i]);
        end
        n_tests++;
        if (obs_q[0].cyc - exp_q[0].cyc != 2) begin
          n_fail++;
          $display("FAIL directed_latency op=%0d: got %0d expected 2", i,
                   obs_q[0].cyc - exp_q[0].cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back(input int d);
    bit acc;
    int n;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'(i % 2), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick(d, acc);
      n_tests++;
      if (!acc) begin
        n_fail++;
        $display("FAIL b2b_accept d=%0d op=%0d: got no accept expected accept", d, i);
      end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    for (int t = 0; t < 12 && obs_q.size() < exp_q.size(); t++) tick(d, acc);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_count d=%0d: got %0d results expected %0d", d, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if ({obs_q[i].tag, obs_q[i].sgn, obs_q[i].prod} !== {exp_q[i].tag, exp_q[i].sgn, exp_q[i].prod}) begin
        n_fail++;
        $display("FAIL b2b_result d=%0d i=%0d: got tag=%h sgn=%b prod=%h expected tag=%h sgn=%b prod=%h",
                 d, i, obs_q[i].tag, obs_q[i].sgn, obs_q[i].prod,
                 exp_q[i].tag, exp_q[i].sgn, exp_q[i].prod);
      end
      n_tests++;
      if (obs_q[i].cyc - exp_q[i].cyc != d + 1 || obs_q[i].cyc != obs_q[0].cyc + i) begin
        n_fail++;
        $display("FAIL b2b_timing d=%0d i=%0d: got latency %0d expected %0d at one result per cycle",
                 d, i, obs_q[i].cyc - exp_q[i].cyc, d + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int d;
    int n;
    d = 2;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (w_out_valid[d] && exp_q.size() > 0) begin
        n_tests++;
        if ({w_prod[d], w_otag[d]} !== {exp_q[0].prod, exp_q[0].tag}) begin
          n_fail++;
          $display("FAIL bp_held cyc=%0d: got prod=%h tag=%h expected prod=%h tag=%h",
                   i, w_prod[d], w_otag[d], exp_q[0].prod, exp_q[0].tag);
        end
      end
      drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick(d, acc);
    end
    n_tests++;
    if ({w_occ[d], w_in_ready[d], 3'(exp_q.size())} !== {3'd3, 1'b0, 3'd3}) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d in_ready=%b accepted=%0d expected occ=3 in_ready=0 accepted=3",
               w_occ[d], w_in_ready[d], exp_q.size());
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (w_in_ready[d] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: got %b expected 1", w_in_ready[d]);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick(d, acc);
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    for (int t = 0; t < 20 && obs_q.size() < exp_q.size(); t++) tick(d, acc);
    n_tests++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != 7) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results of %0d accepted, expected 7 of 7",
               obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if ({obs_q[i].tag, obs_q[i].prod} !== {4'(i), exp_q[i].prod}) begin
        n_fail++;
        $display("FAIL bp_order i=%0d: got tag=%h prod=%h expected tag=%h prod=%h",
                 i, obs_q[i].tag, obs_q[i].prod, 4'(i), exp_q[i].prod);
      end
    end
  endtask

  task automatic test_bubble();
    bit acc;
    int d;
    int n;
    d = 2;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 4'h9, 4'h6); tick(d, acc);
    drive(1'b0, 1'b0, 4'h0, 4'h0); tick(d, acc);
    drive(1'b1, 1'b0, 4'hD, 4'hB); tick(d, acc);
    drive(1'b1, 1'b1, 4'h7, 4'hC); tick(d, acc);
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    tick(d, acc);
    tick(d, acc);
    n_tests++;
    if ({3'(exp_q.size()), w_occ[d], w_in_ready[d]} !== {3'd3, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL bubble_full: got accepted=%0d occ=%0d in_ready=%b expected 3 3 0",
               exp_q.size(), w_occ[d], w_in_ready[d]);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 10 && obs_q.size() < exp_q.size(); t++) tick(d, acc);
    n_tests++;
    if (obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL bubble_count: got %0d results expected 3", obs_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if ({obs_q[i].tag, obs_q[i].sgn, obs_q[i].prod} !== {exp_q[i].tag, exp_q[i].sgn, exp_q[i].prod}) begin
        n_fail++;
        $display("FAIL bubble_order i=%0d: got tag=%h sgn=%b prod=%h expected tag=%h sgn=%b prod=%h",
                 i, obs_q[i].tag, obs_q[i].sgn, obs_q[i].prod,
                 exp_q[i].tag, exp_q[i].sgn, exp_q[i].prod);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit acc;
    int d;
    d = 1;
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'h3, 4'h5); tick(d, acc);
    drive(1'b1, 1'b1, 4'hE, 4'h3); tick(d, acc);
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    n_tests++;
    if ({w_occ[d], w_out_valid[d]} !== {3'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL midflight_pre: got occ=%0d out_valid=%b expected occ=2 out_valid=1",
               w_occ[d], w_out_valid[d]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({w_out_valid[d], w_prod[d], w_osgn[d], w_otag[d], w_occ[d], w_in_ready[d]} !== '0) begin
      n_fail++;
      $display("FAIL midflight_reset: got v=%b p=%h s=%b t=%h occ=%0d rdy=%b expected all 0",
               w_out_valid[d], w_prod[d], w_osgn[d], w_otag[d], w_occ[d], w_in_ready[d]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) tick(d, acc);
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL midflight_stale: got %0d outputs after reset expected 0", obs_q.size());
    end
  endtask

  task automatic test_exhaustive(input int d);
    bit acc;
    int tries;
    int n;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          acc   = 1'b0;
          tries = 0;
          while (!acc && tries < 100) begin
            if ($urandom_range(0, 3) != 0) drive(1'b1, 1'(s), 4'(a), 4'(b));
            else drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 2) != 0);
            n_tests++;
            if (int'(w_occ[d]) != exp_q.size() - obs_q.size()) begin
              n_fail++;
              $display("FAIL exh_occupancy d=%0d: got %0d expected %0d", d, w_occ[d],
                       exp_q.size() - obs_q.size());
            end
            tick(d, acc);
            tries++;
          end
          if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL exh_accept_timeout d=%0d: got no accept in 100 cycles expected accept", d);
          end
        end
      end
    end
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    out_ready = 1'b1;
    for (int t = 0; t < 20 && obs_q.size() < exp_q.size(); t++) tick(d, acc);
    n_tests++;
    if (obs_q.size() != 512 || exp_q.size() != 512) begin
      n_fail++;
      $display("FAIL exh_count d=%0d: got %0d results of %0d accepted expected 512 of 512",
               d, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if ({obs_q[i].tag, obs_q[i].sgn, obs_q[i].prod} !== {exp_q[i].tag, exp_q[i].sgn, exp_q[i].prod}) begin
        n_fail++;
        $display("FAIL exh_result d=%0d i=%0d: got tag=%h sgn=%b prod=%h expected tag=%h sgn=%b prod=%h",
                 d, i, obs_q[i].tag, obs_q[i].sgn, obs_q[i].prod,
                 exp_q[i].tag, exp_q[i].sgn, exp_q[i].prod);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion after 2 ms expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(1);
    test_back_to_back(3);
    test_backpressure();
    test_bubble();
    test_reset_midflight();
    for (int d = 0; d < ND; d++) test_exhaustive(d);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
